hdmi_config_sequencer: RTL and testbench

Drives the HDMI transmitter (ADV7513) register initialisation through the I2C write controller that sits directly downstream.
- Waits a power-up delay, then walks an internal register ROM.
- For each entry, presents {slave address, register, value} as a 24-bit word and pulses a write.
- Checks the acknowledge result and retries on NACK.
- Flags completion or failure to the video pipeline.

---
 rtl/hdmi_config_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_hdmi_config_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_config_sequencer.sv
// ADV7513 register initialisation sequencer driving a downstream I2C write controller.
// Optional build macro HPD_RECONFIG_EN adds a hot-plug-detect input that re-triggers configuration.
module hdmi_config_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
  parameter int unsigned POWER_UP_DELAY = 1000000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef HPD_RECONFIG_EN
  input  logic        hpd,
`endif
  output logic [23:0] i2c_data,
  output logic        i2c_enable,
  input  logic        i2c_ack,
  input  logic        i2c_end,
  output logic        config_done,
  output logic        config_error,
  output logic [3:0]  cur_index
);

  localparam int unsigned LutSize = 12;
  localparam int unsigned CntMax  = (POWER_UP_DELAY > GAP_CYCLES) ? POWER_UP_DELAY : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    StPowerWait, StLoad, StWrite, StWaitEnd, StRelease, StCheck, StGap, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [3:0]          idx_q, idx_d;
  logic [23:0]         data_q, data_d;
  logic                en_q, en_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                restart;
  logic                in_final;

  function automatic logic [15:0] rom_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_entry = 16'h4110;
      4'd1:    rom_entry = 16'h9803;
      4'd2:    rom_entry = 16'h9AE0;
      4'd3:    rom_entry = 16'h9C30;
      4'd4:    rom_entry = 16'h9D61;
      4'd5:    rom_entry = 16'hA2A4;
      4'd6:    rom_entry = 16'hA3A4;
      4'd7:    rom_entry = 16'hE0D0;
      4'd8:    rom_entry = 16'hF900;
      4'd9:    rom_entry = 16'h1500;
      4'd10:   rom_entry = 16'h1630;
      4'd11:   rom_entry = 16'hAF06;
      default: rom_entry = 16'h0000;
    endcase
  endfunction

  assign in_final = (state_q == StDone) || (state_q == StError);

`ifdef HPD_RECONFIG_EN
  logic hpd_meta_q, hpd_sync_q, hpd_prev_q, pend_q, pend_d, hpd_rise;

  assign hpd_rise = hpd_sync_q & ~hpd_prev_q;
  // An edge seen mid-sequence is remembered and honoured once the sequence settles.
  assign pend_d   = in_final ? 1'b0 : (pend_q | hpd_rise);
  assign restart  = start | hpd_rise | pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hpd_meta_q <= 1'b0;
      hpd_sync_q <= 1'b0;
      hpd_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      hpd_meta_q <= hpd;
      hpd_sync_q <= hpd_meta_q;
      hpd_prev_q <= hpd_sync_q;
      pend_q     <= pend_d;
    end
  end
`else
  assign restart = start;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    data_d  = data_q;
    en_d    = en_q;
    ack_d   = ack_q;
    done_d  = done_q;
    error_d = error_q;
    unique case (state_q)
      StPowerWait: begin
        if (cnt_q == CntW'(POWER_UP_DELAY - 1)) begin
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLoad: begin
        data_d  = {SLAVE_ADDR, rom_entry(idx_q)};
        cnt_d   = '0;
        state_d = StWrite;
      end
      // One settle cycle so data leads enable and LOAD-to-enable spans three cycles.
      StWrite: begin
        if (cnt_q == '0) begin
          cnt_d = CntW'(1);
        end else begin
          cnt_d   = '0;
          en_d    = 1'b1;
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (i2c_end) begin
          ack_d   = i2c_ack;
          en_d    = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!i2c_end) state_d = StCheck;
      end
      StCheck: begin
        if (!ack_q) begin
          retry_d = '0;
          if (idx_q == 4'(LutSize - 1)) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StGap;
          end
        end else if (retry_q < RetryW'(MAX_RETRY)) begin
          retry_d = retry_q + RetryW'(1);
          state_d = StGap;
        end else begin
          error_d = 1'b1;
          state_d = StError;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone, StError: begin
`ifdef HPD_RECONFIG_EN
        if (state_q == StDone && !hpd_sync_q) done_d = 1'b0;
`endif
        if (restart) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          cnt_d   = '0;
          state_d = StPowerWait;
        end
      end
      default: state_d = StPowerWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StPowerWait;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign i2c_data     = data_q;
  assign i2c_enable   = en_q;
  assign config_done  = done_q;
  assign config_error = error_q;
  assign cur_index    = idx_q;

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer with a small I2C controller model that logs each write.
module tb_hdmi_config_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] i2c_data;
  logic        i2c_enable;
  logic        i2c_ack = 1'b0;
  logic        i2c_end = 1'b0;
  logic        config_done, config_error;
  logic [3:0]  cur_index;
`ifdef HPD_RECONFIG_EN
  logic        hpd = 1'b0;
`endif

  int          checks = 0;
  int          fails = 0;
  logic [23:0] wlog[$];
  logic [23:0] nack_word = 24'hFFFFFF;
  int          nack_left = 0;

  hdmi_config_sequencer #(
    .SLAVE_ADDR    (8'h72),
    .POWER_UP_DELAY(20),
    .GAP_CYCLES    (4),
    .MAX_RETRY     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef HPD_RECONFIG_EN
    .hpd         (hpd),
`endif
    .i2c_data    (i2c_data),
    .i2c_enable  (i2c_enable),
    .i2c_ack     (i2c_ack),
    .i2c_end     (i2c_end),
    .config_done (config_done),
    .config_error(config_error),
    .cur_index   (cur_index)
  );

  always #5 clk = ~clk;

  // Controller model: logs the word on enable rise, raises end 10 cycles later, drops it with enable.
  initial begin
    bit busy = 0;
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!i2c_enable) begin
        i2c_end = 1'b0;
        busy = 0;
      end else if (!busy) begin
        busy = 1;
        cnt = 0;
        wlog.push_back(i2c_data);
      end else if (!i2c_end) begin
        cnt++;
        if (cnt == 10) begin
          i2c_end = 1'b1;
          if (i2c_data == nack_word && nack_left > 0) begin
            i2c_ack = 1'b1;
            nack_left--;
          end else begin
            i2c_ack = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wlog.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_final(input string tag);
    int n = 0;
    while (!(config_done || config_error) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(config_done || config_error), 32'd1);
  endtask

  task automatic wait_idx_en(input string tag, input logic [3:0] idx, input bit need_en);
    int n = 0;
    while (!(cur_index == idx && (!need_en || i2c_enable)) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(cur_index == idx && (!need_en || i2c_enable)), 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_enable", 32'(i2c_enable), 32'd0);
    check("rst_data", 32'(i2c_data), 32'h0);
    check("rst_done", 32'(config_done), 32'd0);
    check("rst_error", 32'(config_error), 32'd0);
    check("rst_index", 32'(cur_index), 32'd0);

    // 1. Normal run
    wait_final("t1_timeout");
    check("t1_writes", 32'(wlog.size()), 32'd12);
    check("t1_first", 32'(wlog[0]), 32'h724110);
    check("t1_mid", 32'(wlog[5]), 32'h72A2A4);
    check("t1_last", 32'(wlog[11]), 32'h72AF06);
    check("t1_done", 32'(config_done), 32'd1);
    check("t1_error", 32'(config_error), 32'd0);

    // 5. Start from DONE restarts; a start pulse during GAP is ignored
    wlog.delete();
    pulse_start();
    check("t5_done_clr", 32'(config_done), 32'd0);
    check("t5_index_clr", 32'(cur_index), 32'd0);
    wait_idx_en("t5_reach_gap", 4'd2, 1'b0);
    pulse_start();
    wait_final("t5_timeout");
    check("t5_gap_ignored", 32'(wlog.size()), 32'd12);
    check("t5_done", 32'(config_done), 32'd1);
    wlog.delete();
    pulse_start();
    check("t5_done_clr2", 32'(config_done), 32'd0);
    wait_final("t5_timeout2");
    check("t5_rerun_writes", 32'(wlog.size()), 32'd12);
    check("t5_rerun_first", 32'(wlog[0]), 32'h724110);

    // 2. Single NACK on entry 3
    nack_word = 24'h729C30;
    nack_left = 1;
    do_reset();
    wait_final("t2_timeout");
    check("t2_writes", 32'(wlog.size()), 32'd13);
    check("t2_entry3_a", 32'(wlog[3]), 32'h729C30);
    check("t2_entry3_b", 32'(wlog[4]), 32'h729C30);
    check("t2_entry4", 32'(wlog[5]), 32'h729D61);
    check("t2_done", 32'(config_done), 32'd1);

    // 3. Persistent NACK on entry 5
    nack_word = 24'h72A2A4;
    nack_left = 100;
    do_reset();
    wait_final("t3_timeout");
    check("t3_error", 32'(config_error), 32'd1);
    check("t3_done", 32'(config_done), 32'd0);
    check("t3_index", 32'(cur_index), 32'd5);
    check("t3_writes", 32'(wlog.size()), 32'd9);
    check("t3_last", 32'(wlog[8]), 32'h72A2A4);
    repeat (30) tick();
    check("t3_enable_idle", 32'(i2c_enable), 32'd0);
    check("t3_error_held", 32'(config_error), 32'd1);

    // 4. Reset during WAIT_END of entry 7
    nack_left = 0;
    do_reset();
    wait_idx_en("t4_reach_e7", 4'd7, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_enable_drop", 32'(i2c_enable), 32'd0);
    check("t4_index", 32'(cur_index), 32'd0);
    wlog.delete();
    begin
      int n = 0;
      while (wlog.size() == 0 && n < 3000) begin
        tick();
        n++;
      end
    end
    check("t4_rewrite", 32'(wlog.size() > 0), 32'd1);
    check("t4_first", 32'(wlog[0]), 32'h724110);

`ifdef HPD_RECONFIG_EN
    // 6. HPD edge mid-sequence triggers a second full run
    do_reset();
    wait_idx_en("t6_reach_e4", 4'd4, 1'b0);
    hpd = 1'b1;
    repeat (3) tick();
    hpd = 1'b0;
    wait_final("t6_timeout");
    check("t6_done_pulse", 32'(config_done), 32'd1);
    tick();
    check("t6_done_drop", 32'(config_done), 32'd0);
    wait_final("t6_timeout2");
    check("t6_writes", 32'(wlog.size()), 32'd24);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
